// File: rtl/spi2bus_pkg.sv
// spi2bus_pkg: shared types and SPI mode helpers for the SPI-to-bus bridge.
//   state_t        - bridge transaction state
//   EDGE_RISE/FALL - which synchronized sck transition acts as the sample edge
//   sample_edge()  - maps CPOL/CPHA onto the sample-edge selector
package spi2bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_edge(input logic cpol, input logic cpha);
        return (cpol == cpha) ? EDGE_RISE : EDGE_FALL;
    endfunction

endpackage

// File: rtl/spi2bus_if.sv
// spi2bus_if: SPI pins plus the parallel bus side of the bridge.
//   slave  - bridge view (SPI slave, bus master)
//   master - environment view (SPI master and bus target)
interface spi2bus_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  mosi;
    logic                  ss;
    logic                  sck;
    logic                  miso;
    logic [DATA_WIDTH-1:0] data_bus_out;
    logic [DATA_WIDTH-1:0] data_bus_in;
    logic [ADDR_WIDTH-1:0] addr_bus;
    logic                  wr;
    logic                  rd;
    logic                  rd_ack;
    logic                  strobe;
    logic                  cycle;
    logic                  rd_err;

    modport slave (
        input  mosi, ss, sck, data_bus_in, rd_ack,
        output miso, data_bus_out, addr_bus, wr, rd, strobe, cycle, rd_err
    );

    modport master (
        output mosi, ss, sck, data_bus_in, rd_ack,
        input  miso, data_bus_out, addr_bus, wr, rd, strobe, cycle, rd_err
    );
endinterface

// File: rtl/spi2bus_sync.sv
// spi2bus_sync: brings sck/ss/mosi into the clk domain and produces
// single-cycle event pulses.
//   clk, resetn   - system clock, async active-low reset
//   i_sck/i_ss/i_mosi - raw SPI pins
//   o_sample      - sample edge of synchronized sck
//   o_shift       - shift edge of synchronized sck
//   o_ss_fall     - synchronized ss falling edge
//   o_ss_high     - synchronized ss level is high (deselected)
//   o_mosi        - mosi delayed to line up with the edge pulses
module spi2bus_sync
    import spi2bus_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_sck,
    input  logic i_ss,
    input  logic i_mosi,
    output logic o_sample,
    output logic o_shift,
    output logic o_ss_fall,
    output logic o_ss_high,
    output logic o_mosi
);
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_dly;
    logic                   r_sck_last;
    logic                   r_ss_last;
    logic                   w_rise;
    logic                   w_fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sck_sync <= {SYNC_STAGES{CPOL}};
            r_ss_sync  <= '1;
            r_mosi_dly <= '0;
            r_sck_last <= CPOL;
            r_ss_last  <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
            r_mosi_dly <= {r_mosi_dly[SYNC_STAGES-2:0], i_mosi};
            r_sck_last <= r_sck_sync[SYNC_STAGES-1];
            r_ss_last  <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise    = r_sck_sync[SYNC_STAGES-1] & ~r_sck_last;
    assign w_fall    = ~r_sck_sync[SYNC_STAGES-1] & r_sck_last;
    assign o_sample  = (sample_edge(CPOL, CPHA) == EDGE_RISE) ? w_rise : w_fall;
    assign o_shift   = (sample_edge(CPOL, CPHA) == EDGE_RISE) ? w_fall : w_rise;
    assign o_ss_fall = ~r_ss_sync[SYNC_STAGES-1] & r_ss_last;
    assign o_ss_high = r_ss_sync[SYNC_STAGES-1];
    // mosi sees the same flop count as sck, so it is aligned with o_sample.
    assign o_mosi    = r_mosi_dly[SYNC_STAGES-1];

endmodule

// File: rtl/spi2bus_bridge.sv
// spi2bus_bridge: SPI slave that turns a command word plus data words into
// bus writes/reads. Command word = {addr, auto_inc, rd_wrn}.
//   clk, resetn - system clock, async active-low reset
//   bus         - spi2bus_if.slave: SPI pins, bus address/data, wr/rd strobes,
//                 rd_ack handshake, cycle and sticky rd_err status
//
// state   | meaning
// IDLE    | ss deasserted, outputs hold
// CMD     | shifting in the command word
// WR_DATA | each word completes a bus write
// RD_DATA | words shift out read data, rd issued per word
module spi2bus_bridge
    import spi2bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit BYTE_SWAP   = 1'b1,
    parameter int SYNC_STAGES = 3
) (
    input  logic      clk,
    input  logic      resetn,
    spi2bus_if.slave  bus
);
    localparam int                 CNT_W    = $clog2(DATA_WIDTH);
    localparam int                 NBYTES   = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                r_state, w_state_nxt;
    logic                  w_sample, w_shift, w_ss_fall, w_ss_high, w_mosi;
    logic                  w_active, w_boundary;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_in_sr, r_miso_sr, r_hold, r_data_out;
    logic [DATA_WIDTH-1:0] w_word, w_word_sw, w_hold_sw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr, r_rd, r_auto_inc, r_issued, r_ack_seen, r_sampled, r_rd_err;

    spi2bus_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .CPOL        (CPOL),
        .CPHA        (CPHA)
    ) u_sync (
        .clk       (clk),
        .resetn    (resetn),
        .i_sck     (bus.sck),
        .i_ss      (bus.ss),
        .i_mosi    (bus.mosi),
        .o_sample  (w_sample),
        .o_shift   (w_shift),
        .o_ss_fall (w_ss_fall),
        .o_ss_high (w_ss_high),
        .o_mosi    (w_mosi)
    );

    assign w_active   = (r_state != IDLE) && !w_ss_high;
    assign w_boundary = w_active && w_sample && (r_bit_cnt == LAST_BIT);
    assign w_word     = {r_in_sr[DATA_WIDTH-2:0], w_mosi};

    always_comb begin
        w_word_sw = w_word;
        w_hold_sw = r_hold;
        if (BYTE_SWAP) begin
            for (int b = 0; b < NBYTES; b++) begin
                w_word_sw[8*b +: 8] = w_word[DATA_WIDTH-8-8*b +: 8];
                w_hold_sw[8*b +: 8] = r_hold[DATA_WIDTH-8-8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_nxt = CMD;
            CMD: begin
                if (w_ss_high)       w_state_nxt = IDLE;
                else if (w_boundary) w_state_nxt = w_word[0] ? RD_DATA : WR_DATA;
            end
            WR_DATA,
            RD_DATA: if (w_ss_high) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt  <= '0;
            r_in_sr    <= '0;
            r_miso_sr  <= '0;
            r_hold     <= '0;
            r_data_out <= '0;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_auto_inc <= 1'b0;
            r_issued   <= 1'b0;
            r_ack_seen <= 1'b0;
            r_sampled  <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            r_rd <= 1'b0;

            if (bus.rd_ack) begin
                r_hold     <= bus.data_bus_in;
                r_ack_seen <= 1'b1;
            end else if (r_rd) begin
                r_ack_seen <= 1'b0;
            end

            if ((r_wr || r_rd) && r_auto_inc) r_addr <= r_addr + ADDR_WIDTH'(1);

            if (r_state == IDLE && w_ss_fall) begin
                r_bit_cnt <= '0;
                r_sampled <= 1'b0;
                r_issued  <= 1'b0;
                r_rd_err  <= 1'b0;
                r_miso_sr <= '0;
            end else if (w_active) begin
                if (w_sample) begin
                    r_in_sr   <= w_word;
                    r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + CNT_W'(1);
                    r_sampled <= !w_boundary;
                end
                if (w_boundary) begin
                    case (r_state)
                        CMD: begin
                            r_addr     <= ADDR_WIDTH'(w_word[DATA_WIDTH-1:2]);
                            r_auto_inc <= w_word[1];
                            r_rd       <= w_word[0];
                            r_issued   <= w_word[0];
                        end
                        WR_DATA: begin
                            r_data_out <= w_word_sw;
                            r_wr       <= r_auto_inc || !r_issued;
                            r_issued   <= 1'b1;
                        end
                        RD_DATA: r_rd <= r_auto_inc;
                        default: ;
                    endcase
                end
                // The read word is loaded on the first shift edge of each word
                // rather than at the boundary itself: that gives the bus half an
                // sck period to answer the rd issued at the boundary, and that
                // edge is exactly where the MSB must be presented in all modes.
                if (w_shift) begin
                    if (r_state == RD_DATA && !r_sampled) begin
                        if (r_ack_seen) begin
                            r_miso_sr <= w_hold_sw;
                        end else begin
                            r_miso_sr <= '1;
                            r_rd_err  <= 1'b1;
                        end
                    end else if (r_sampled) begin
                        r_miso_sr <= {r_miso_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.miso         = r_miso_sr[DATA_WIDTH-1];
    assign bus.addr_bus     = r_addr;
    assign bus.data_bus_out = r_data_out;
    assign bus.wr           = r_wr;
    assign bus.rd           = r_rd;
    assign bus.strobe       = r_wr | r_rd;
    assign bus.cycle        = (r_state != IDLE);
    assign bus.rd_err       = r_rd_err;

endmodule

// File: tb/tb_spi2bus_bridge.sv
module tb_spi2bus_bridge;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    spi2bus_if #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) if0();
    spi2bus_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) if3();

    spi2bus_bridge #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0),
                     .BYTE_SWAP(1'b1), .SYNC_STAGES(3))
        dut0 (.clk(clk), .resetn(resetn), .bus(if0.slave));

    spi2bus_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1),
                     .BYTE_SWAP(1'b1), .SYNC_STAGES(3))
        dut3 (.clk(clk), .resetn(resetn), .bus(if3.slave));

    int vectors = 0;
    int errors  = 0;

    int          wr_cnt0, wr_cnt3, rd_cnt3, ack_i;
    bit          ack_en;
    logic [13:0] wr_addr0 [0:7];
    logic [15:0] wr_data0 [0:7];
    logic [15:0] rd_addr3 [0:7];
    logic [15:0] ack_data [0:3];
    logic [15:0] rx;

    // Bus-side monitor and read responder (acks one cycle after each rd).
    initial begin
        if0.rd_ack = 1'b0; if0.data_bus_in = '0;
        if3.rd_ack = 1'b0; if3.data_bus_in = '0;
        forever begin
            @(negedge clk);
            if (if0.wr === 1'b1) begin
                if (wr_cnt0 < 8) begin
                    wr_addr0[wr_cnt0] = if0.addr_bus;
                    wr_data0[wr_cnt0] = if0.data_bus_out;
                end
                wr_cnt0++;
            end
            if (if3.wr === 1'b1) wr_cnt3++;
            if (if3.rd === 1'b1) begin
                if (rd_cnt3 < 8) rd_addr3[rd_cnt3] = if3.addr_bus;
                rd_cnt3++;
            end
            if (if3.rd === 1'b1 && ack_en) begin
                if3.rd_ack = 1'b1;
                if3.data_bus_in = ack_data[ack_i];
                if (ack_i < 3) ack_i++;
            end else begin
                if3.rd_ack = 1'b0;
            end
        end
    end

    task automatic clear_counts();
        wr_cnt0 = 0; wr_cnt3 = 0; rd_cnt3 = 0; ack_i = 0;
    endtask

    task automatic begin0();
        if0.ss = 1'b0; #(2*HALF);
    endtask
    task automatic end0();
        #HALF; if0.ss = 1'b1; #(2*HALF);
    endtask
    task automatic xfer0(input logic [15:0] w, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) begin
            if0.mosi = w[i]; #HALF; if0.sck = 1'b1; #HALF; if0.sck = 1'b0;
        end
    endtask

    task automatic begin3();
        if3.ss = 1'b0; #(2*HALF);
    endtask
    task automatic end3();
        #HALF; if3.ss = 1'b1; #(2*HALF);
    endtask
    task automatic xfer3(input logic [15:0] w, input int nbits, output logic [15:0] r);
        r = '0;
        for (int i = 15; i > 15 - nbits; i--) begin
            if3.sck = 1'b0; if3.mosi = w[i]; #HALF;
            r = {r[14:0], if3.miso}; if3.sck = 1'b1; #HALF;
        end
    endtask

    task automatic check_dut3_zero(input string tag);
        vectors++; if (if3.addr_bus !== 16'h0) begin errors++; $display("FAIL %s addr_bus got %h want 0000", tag, if3.addr_bus); end
        vectors++; if (if3.data_bus_out !== 16'h0) begin errors++; $display("FAIL %s data_bus_out got %h want 0000", tag, if3.data_bus_out); end
        vectors++; if ({if3.wr, if3.rd, if3.strobe} !== 3'b000) begin errors++; $display("FAIL %s wr/rd/strobe got %b want 000", tag, {if3.wr, if3.rd, if3.strobe}); end
        vectors++; if (if3.cycle !== 1'b0) begin errors++; $display("FAIL %s cycle got %b want 0", tag, if3.cycle); end
        vectors++; if (if3.rd_err !== 1'b0) begin errors++; $display("FAIL %s rd_err got %b want 0", tag, if3.rd_err); end
        vectors++; if (if3.miso !== 1'b0) begin errors++; $display("FAIL %s miso got %b want 0", tag, if3.miso); end
    endtask

    task automatic test_reset();
        if0.ss = 1'b1; if0.sck = 1'b0; if0.mosi = 1'b0;
        if3.ss = 1'b1; if3.sck = 1'b1; if3.mosi = 1'b0;
        ack_en = 1'b0; clear_counts();
        #1;
        check_dut3_zero("reset3");
        vectors++; if ({if0.cycle, if0.miso, if0.wr} !== 3'b000) begin errors++; $display("FAIL reset0 cycle/miso/wr got %b want 000", {if0.cycle, if0.miso, if0.wr}); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Mode 0 write, auto_inc off: only the first data word produces a wr.
    task automatic test_write_single();
        clear_counts();
        begin0();
        xfer0(16'h0010, 16);
        xfer0(16'h3412, 16);
        vectors++; if (if0.addr_bus !== 14'h0004) begin errors++; $display("FAIL wr1 addr_bus got %h want 0004", if0.addr_bus); end
        vectors++; if (if0.data_bus_out !== 16'h1234) begin errors++; $display("FAIL wr1 data_bus_out got %h want 1234", if0.data_bus_out); end
        vectors++; if (wr_cnt0 !== 1) begin errors++; $display("FAIL wr1 wr pulses got %0d want 1", wr_cnt0); end
        vectors++; if (if0.cycle !== 1'b1) begin errors++; $display("FAIL wr1 cycle got %b want 1", if0.cycle); end
        xfer0(16'h5566, 16);
        end0();
        vectors++; if (wr_cnt0 !== 1) begin errors++; $display("FAIL wr1 extra word pulses got %0d want 1", wr_cnt0); end
        vectors++; if (if0.addr_bus !== 14'h0004) begin errors++; $display("FAIL wr1 addr hold got %h want 0004", if0.addr_bus); end
        vectors++; if (if0.cycle !== 1'b0) begin errors++; $display("FAIL wr1 idle cycle got %b want 0", if0.cycle); end
    endtask

    // Auto-increment write from the top of the 14-bit address space.
    task automatic test_write_wrap();
        clear_counts();
        begin0();
        xfer0(16'hFFFE, 16);
        xfer0(16'h0100, 16);
        xfer0(16'h0200, 16);
        end0();
        vectors++; if (wr_cnt0 !== 2) begin errors++; $display("FAIL wrap wr pulses got %0d want 2", wr_cnt0); end
        vectors++; if (wr_addr0[0] !== 14'h3FFF || wr_data0[0] !== 16'h0001) begin errors++; $display("FAIL wrap first wr got %h/%h want 3fff/0001", wr_addr0[0], wr_data0[0]); end
        vectors++; if (wr_addr0[1] !== 14'h0000 || wr_data0[1] !== 16'h0002) begin errors++; $display("FAIL wrap second wr got %h/%h want 0000/0002", wr_addr0[1], wr_data0[1]); end
        vectors++; if (if0.addr_bus !== 14'h0001) begin errors++; $display("FAIL wrap final addr got %h want 0001", if0.addr_bus); end
    endtask

    // ss rises after 9 data bits: nothing written, then a clean transaction.
    task automatic test_abort();
        clear_counts();
        begin0();
        xfer0(16'h0014, 16);
        xfer0(16'hABCD, 9);
        end0();
        vectors++; if (wr_cnt0 !== 0) begin errors++; $display("FAIL abort wr pulses got %0d want 0", wr_cnt0); end
        vectors++; if (if0.cycle !== 1'b0) begin errors++; $display("FAIL abort cycle got %b want 0", if0.cycle); end
        vectors++; if (if0.data_bus_out !== 16'h0002) begin errors++; $display("FAIL abort data hold got %h want 0002", if0.data_bus_out); end
        begin0();
        xfer0(16'h0018, 16);
        xfer0(16'h7788, 16);
        end0();
        vectors++; if (wr_cnt0 !== 1 || wr_addr0[0] !== 14'h0006) begin errors++; $display("FAIL abort next wr got %0d@%h want 1@0006", wr_cnt0, wr_addr0[0]); end
        vectors++; if (if0.data_bus_out !== 16'h8877) begin errors++; $display("FAIL abort next data got %h want 8877", if0.data_bus_out); end
    endtask

    // Mode 3 auto-increment read.
    task automatic test_read_autoinc();
        clear_counts();
        ack_en = 1'b1;
        ack_data[0] = 16'hAABB; ack_data[1] = 16'hCCDD; ack_data[2] = 16'h5A5A; ack_data[3] = 16'h0;
        begin3();
        xfer3(16'h0023, 16, rx);
        xfer3(16'h0000, 16, rx);
        vectors++; if (rx !== 16'hBBAA) begin errors++; $display("FAIL rdinc word1 miso got %h want bbaa", rx); end
        xfer3(16'h0000, 16, rx);
        vectors++; if (rx !== 16'hDDCC) begin errors++; $display("FAIL rdinc word2 miso got %h want ddcc", rx); end
        end3();
        vectors++; if (rd_cnt3 !== 3) begin errors++; $display("FAIL rdinc rd pulses got %0d want 3", rd_cnt3); end
        vectors++; if (rd_addr3[0] !== 16'h0008 || rd_addr3[1] !== 16'h0009 || rd_addr3[2] !== 16'h000A) begin errors++; $display("FAIL rdinc rd addrs got %h %h %h want 0008 0009 000a", rd_addr3[0], rd_addr3[1], rd_addr3[2]); end
        vectors++; if (if3.rd_err !== 1'b0) begin errors++; $display("FAIL rdinc rd_err got %b want 0", if3.rd_err); end
    endtask

    // Read without rd_ack: all-ones on miso, sticky rd_err until next ss fall.
    task automatic test_read_underrun();
        clear_counts();
        ack_en = 1'b0;
        begin3();
        xfer3(16'h0031, 16, rx);
        xfer3(16'h0000, 16, rx);
        end3();
        vectors++; if (rx !== 16'hFFFF) begin errors++; $display("FAIL underrun miso got %h want ffff", rx); end
        vectors++; if (if3.rd_err !== 1'b1) begin errors++; $display("FAIL underrun rd_err got %b want 1", if3.rd_err); end
        vectors++; if (rd_cnt3 !== 1 || rd_addr3[0] !== 16'h000C) begin errors++; $display("FAIL underrun rd got %0d@%h want 1@000c", rd_cnt3, rd_addr3[0]); end
        begin3();
        vectors++; if (if3.rd_err !== 1'b0) begin errors++; $display("FAIL underrun rd_err clear got %b want 0", if3.rd_err); end
        xfer3(16'h0080, 16, rx);
        xfer3(16'h0102, 16, rx);
        end3();
        vectors++; if (wr_cnt3 !== 1 || if3.addr_bus !== 16'h0020 || if3.data_bus_out !== 16'h0201) begin errors++; $display("FAIL mode3 write got %0d %h/%h want 1 0020/0201", wr_cnt3, if3.addr_bus, if3.data_bus_out); end
    endtask

    // Reset in the middle of a read, then a normal read.
    task automatic test_reset_mid_read();
        clear_counts();
        ack_en = 1'b1;
        ack_data[0] = 16'h9999; ack_data[1] = 16'h9999;
        begin3();
        xfer3(16'h0023, 16, rx);
        xfer3(16'h0000, 5, rx);
        resetn = 1'b0;
        #1;
        check_dut3_zero("midrst");
        vectors++; if (if0.data_bus_out !== 16'h0) begin errors++; $display("FAIL midrst dut0 data got %h want 0000", if0.data_bus_out); end
        if3.ss = 1'b1; if3.sck = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        clear_counts();
        ack_data[0] = 16'h1357;
        begin3();
        xfer3(16'h0041, 16, rx);
        xfer3(16'h0000, 16, rx);
        end3();
        vectors++; if (rx !== 16'h5713) begin errors++; $display("FAIL postrst miso got %h want 5713", rx); end
        vectors++; if (rd_cnt3 !== 1 || rd_addr3[0] !== 16'h0010) begin errors++; $display("FAIL postrst rd got %0d@%h want 1@0010", rd_cnt3, rd_addr3[0]); end
        vectors++; if (if3.rd_err !== 1'b0 || wr_cnt3 !== 0) begin errors++; $display("FAIL postrst rd_err/wr got %b/%0d want 0/0", if3.rd_err, wr_cnt3); end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_write_wrap();
        test_abort();
        test_read_autoinc();
        test_read_underrun();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
